// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of up to N_WAY renamed instructions per cycle.
// Completion arrives out of order on the CDB and is matched by physical tag.
module reorder_buffer #(
  parameter int N_WAY    = 3,
  parameter int N_ROB    = 32,
  parameter int CDB_BITS = 7,
  parameter int SD       = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [$clog2(N_WAY):0]         disp_num,
  input  logic [N_WAY-1:0][CDB_BITS-1:0] disp_T,
  input  logic [N_WAY-1:0][CDB_BITS-1:0] disp_Told,
  input  logic [N_WAY-1:0][4:0]          disp_dest,
  input  logic [N_WAY-1:0]               cdb_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0] cdb_tag,
  output logic [N_WAY-1:0]               dispatched,
  output logic [N_WAY-1:0][CDB_BITS-1:0] rob_told,
  output logic [N_WAY-1:0]               retire_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0] retire_T,
  output logic [N_WAY-1:0][4:0]          retire_dest,
  output logic [$clog2(N_WAY):0]         rob_free_num
);

  localparam int NUM_W = $clog2(N_WAY) + 1;
  localparam int PTR_W = (N_ROB > 1) ? $clog2(N_ROB) : 1;
  localparam int CNT_W = $clog2(N_ROB + 1);

  // SD only modelled a flop delay in the legacy simulation code; these flops update without delay.
  if (SD < 0) begin : g_sd_range
  end

  logic [N_ROB-1:0]    valid_q;
  logic [N_ROB-1:0]    valid_d;
  logic [N_ROB-1:0]    complete_q;
  logic [N_ROB-1:0]    complete_d;
  logic [CDB_BITS-1:0] t_q    [N_ROB];
  logic [CDB_BITS-1:0] t_d    [N_ROB];
  logic [CDB_BITS-1:0] told_q [N_ROB];
  logic [CDB_BITS-1:0] told_d [N_ROB];
  logic [4:0]          dest_q [N_ROB];
  logic [4:0]          dest_d [N_ROB];
  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    head_d;
  logic [PTR_W-1:0]    tail_q;
  logic [PTR_W-1:0]    tail_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  int                  accept_cnt_s;
  int                  retire_cnt_s;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr, input int offset);
    int sum;
    sum = int'(ptr) + offset;
    sum = (sum >= N_ROB) ? (sum - N_ROB) : sum;
    return PTR_W'(sum);
  endfunction

  function automatic logic cdb_hit(
    input logic [CDB_BITS-1:0]             tag,
    input logic [N_WAY-1:0]                lane_valid,
    input logic [N_WAY-1:0][CDB_BITS-1:0]  lane_tag
  );
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < N_WAY; l++) begin
      hit = hit | (lane_valid[l] & (lane_tag[l] == tag));
    end
    return hit & (tag != {CDB_BITS{1'b0}});
  endfunction

  // Free space and dispatch acceptance look only at registered occupancy.
  always_comb begin
    int free;
    free         = N_ROB - int'(count_q);
    rob_free_num = (free < N_WAY) ? NUM_W'(free) : NUM_W'(N_WAY);
    accept_cnt_s = 0;
    for (int i = 0; i < N_WAY; i++) begin
      dispatched[i] = (i < int'(disp_num)) && (i < free) && !flush && !reset;
      accept_cnt_s  = accept_cnt_s + (dispatched[i] ? 1 : 0);
    end
  end

  // Retire the longest complete prefix starting at head, never beyond occupied entries.
  always_comb begin
    logic             chain;
    logic [PTR_W-1:0] idx;
    chain        = !flush && !reset;
    idx          = head_q;
    retire_cnt_s = 0;
    for (int k = 0; k < N_WAY; k++) begin
      idx             = ptr_add(head_q, k);
      chain           = chain && valid_q[idx] && complete_q[idx] && (k < int'(count_q));
      retire_valid[k] = chain;
      rob_told[k]     = chain ? told_q[idx] : {CDB_BITS{1'b0}};
      retire_T[k]     = chain ? t_q[idx] : {CDB_BITS{1'b0}};
      retire_dest[k]  = chain ? dest_q[idx] : 5'd0;
      retire_cnt_s    = retire_cnt_s + (chain ? 1 : 0);
    end
  end

  // Next entry state: CDB completion, retire clear, dispatch write with same-cycle bypass.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = tail_q;
    valid_d    = valid_q;
    complete_d = complete_q;
    t_d        = t_q;
    told_d     = told_q;
    dest_d     = dest_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      valid_d    = {N_ROB{1'b0}};
      complete_d = {N_ROB{1'b0}};
      head_d     = {PTR_W{1'b0}};
      tail_d     = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
    end else begin
      for (int e = 0; e < N_ROB; e++) begin
        complete_d[e] = complete_q[e] | (valid_q[e] & cdb_hit(t_q[e], cdb_valid, cdb_tag));
      end
      for (int k = 0; k < N_WAY; k++) begin
        idx             = ptr_add(head_q, k);
        valid_d[idx]    = retire_valid[k] ? 1'b0 : valid_d[idx];
        complete_d[idx] = retire_valid[k] ? 1'b0 : complete_d[idx];
      end
      // Accepted slots only target free entries, so they never collide with retiring ones.
      for (int i = 0; i < N_WAY; i++) begin
        idx             = ptr_add(tail_q, i);
        valid_d[idx]    = dispatched[i] ? 1'b1 : valid_d[idx];
        complete_d[idx] = dispatched[i] ? cdb_hit(disp_T[i], cdb_valid, cdb_tag) : complete_d[idx];
        t_d[idx]        = dispatched[i] ? disp_T[i] : t_d[idx];
        told_d[idx]     = dispatched[i] ? disp_Told[i] : told_d[idx];
        dest_d[idx]     = dispatched[i] ? disp_dest[i] : dest_d[idx];
      end
      head_d  = ptr_add(head_q, retire_cnt_s);
      tail_d  = ptr_add(tail_q, accept_cnt_s);
      count_d = CNT_W'(int'(count_q) + accept_cnt_s - retire_cnt_s);
    end
  end

  // Entry storage, pointers and occupancy; reset dominates flush and dispatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= {N_ROB{1'b0}};
      complete_q <= {N_ROB{1'b0}};
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int e = 0; e < N_ROB; e++) begin
        t_q[e]    <= {CDB_BITS{1'b0}};
        told_q[e] <= {CDB_BITS{1'b0}};
        dest_q[e] <= 5'd0;
      end
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int e = 0; e < N_ROB; e++) begin
        t_q[e]    <= t_d[e];
        told_q[e] <= told_d[e];
        dest_q[e] <= dest_d[e];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts each
// cycle's accept/retire masks and the retired data stream; a monitor compares at negedge.
module tb_reorder_buffer;

  localparam int NW = 3;
  localparam int NR = 32;
  localparam int CB = 7;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   flush = 1'b0;
  logic [2:0]             disp_num = 3'd0;
  logic [NW-1:0][CB-1:0]  disp_T;
  logic [NW-1:0][CB-1:0]  disp_Told;
  logic [NW-1:0][4:0]     disp_dest;
  logic [NW-1:0]          cdb_valid;
  logic [NW-1:0][CB-1:0]  cdb_tag;
  logic [NW-1:0]          dispatched;
  logic [NW-1:0][CB-1:0]  rob_told;
  logic [NW-1:0]          retire_valid;
  logic [NW-1:0][CB-1:0]  retire_T;
  logic [NW-1:0][4:0]     retire_dest;
  logic [2:0]             rob_free_num;

  always #5 clock = ~clock;

  reorder_buffer #(.N_WAY(NW), .N_ROB(NR), .CDB_BITS(CB), .SD(0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .disp_num(disp_num),
    .disp_T(disp_T), .disp_Told(disp_Told), .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .dispatched(dispatched),
    .rob_told(rob_told), .retire_valid(retire_valid), .retire_T(retire_T),
    .retire_dest(retire_dest), .rob_free_num(rob_free_num)
  );

  typedef struct { logic [CB-1:0] t; logic [CB-1:0] told; logic [4:0] dest; bit done; } item_t;
  typedef struct { bit chk; logic [NW-1:0] disp; logic [NW-1:0] ret; int free; } rec_t;

  item_t         mq[$];   // in-flight instructions in program order
  item_t         rq[$];   // expected retire stream
  rec_t          cq[$];   // expected per-cycle masks
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CB-1:0] next_tag = 7'd0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [CB-1:0] t);
    if (t == 7'd0) return 1'b0;
    for (int l = 0; l < NW; l++) begin
      if (cdb_valid[l] && cdb_tag[l] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [CB-1:0] new_tag();
    next_tag = (next_tag == 7'd127) ? 7'd1 : next_tag + 7'd1;
    return next_tag;
  endfunction

  // Apply one cycle of stimulus, predict its response, advance the model.
  task automatic step(input int num, input bit fl, input bit rs, input bit chk);
    rec_t  r;
    item_t it;
    int    free, nacc, nret;
    disp_num = 3'(num);
    flush    = fl;
    reset    = rs;
    free = NR - mq.size();
    if (free > NW) free = NW;
    nacc = (fl || rs) ? 0 : ((num < free) ? num : free);
    nret = 0;
    if (!(fl || rs)) begin
      while (nret < NW && nret < mq.size() && mq[nret].done) nret++;
    end
    r.chk  = chk;
    r.disp = NW'((1 << nacc) - 1);
    r.ret  = NW'((1 << nret) - 1);
    r.free = free;
    cq.push_back(r);
    if (fl || rs) begin
      mq.delete();
      rq.delete();
    end else begin
      repeat (nret) void'(mq.pop_front());
      for (int i = 0; i < nacc; i++) begin
        it.t = disp_T[i]; it.told = disp_Told[i]; it.dest = disp_dest[i]; it.done = 1'b0;
        mq.push_back(it);
        rq.push_back(it);
      end
      foreach (mq[j]) if (hit(mq[j].t)) mq[j].done = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input int t0);
    for (int i = 0; i < NW; i++) begin
      disp_T[i]    = 7'(t0 + i);
      disp_Told[i] = 7'(i + 1);
      disp_dest[i] = 5'(i + 5);
    end
  endtask

  task automatic set_cdb(input int a, input int b, input int c);
    cdb_tag[0] = 7'(a); cdb_tag[1] = 7'(b); cdb_tag[2] = 7'(c);
    cdb_valid  = {c != 0, b != 0, a != 0};
  endtask

  // Monitor: pops one expected record per cycle and the retire stream in order.
  initial begin
    rec_t  r;
    item_t it;
    forever begin
      @(negedge clock);
      if (cq.size() > 0) begin
        r = cq.pop_front();
        if (r.chk) begin
          check("dispatched", int'(dispatched), int'(r.disp));
          check("rob_free_num", int'(rob_free_num), r.free);
          check("retire_valid", int'(retire_valid), int'(r.ret));
          for (int k = 0; k < NW; k++) begin
            if (r.ret[k] && rq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL retire_stream: slot %0d has no expected entry", k);
            end else if (r.ret[k]) begin
              it = rq.pop_front();
              check("retire_T", int'(retire_T[k]), int'(it.t));
              check("rob_told", int'(rob_told[k]), int'(it.told));
              check("retire_dest", int'(retire_dest[k]), int'(it.dest));
            end else begin
              check("retire_T_idle", int'(retire_T[k]), 0);
              check("rob_told_idle", int'(rob_told[k]), 0);
              check("retire_dest_idle", int'(retire_dest[k]), 0);
            end
          end
        end
      end
    end
  end

  initial begin
    int num, sel;
    set_disp(0);
    set_cdb(0, 0, 0);
    @(posedge clock);
    #1;
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);

    // basic dispatch, then out-of-order completion 35, 34, 33
    set_disp(33);       step(3, 1'b0, 1'b0, 1'b1);
    set_cdb(35, 0, 0);  step(0, 1'b0, 1'b0, 1'b1);
    set_cdb(0, 34, 0);  step(0, 1'b0, 1'b0, 1'b1);
    set_cdb(33, 0, 0);  step(0, 1'b0, 1'b0, 1'b1);
    set_cdb(0, 0, 0);   step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);

    // bypass at head of an empty buffer
    set_disp(40); set_cdb(40, 0, 0); step(1, 1'b0, 1'b0, 1'b1);
    set_cdb(0, 0, 0);                step(0, 1'b0, 1'b0, 1'b1);

    // fill to full, then head retire while dispatch is refused
    for (int c = 0; c < 11; c++) begin
      set_disp(44 + 3 * c);
      step(3, 1'b0, 1'b0, 1'b1);
    end
    step(3, 1'b0, 1'b0, 1'b1);
    set_cdb(44, 0, 0); step(3, 1'b0, 1'b0, 1'b1);
    set_cdb(0, 0, 0);  step(3, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);

    // flush, then reset, each with 10 entries and a complete head
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 4; c++) begin
        set_disp(90 + 3 * c);
        step((c == 3) ? 1 : 3, 1'b0, 1'b0, 1'b1);
      end
      set_cdb(90, 91, 95);
      step(0, 1'b0, 1'b0, 1'b1);
      set_cdb(0, 0, 0);
      step(0, pass == 0, pass == 1, 1'b1);
      step(0, 1'b0, 1'b0, 1'b1);
    end

    // randomized traffic: wrap-around, bypass, stray tags, zero tags, flush/reset
    for (int c = 0; c < 3000; c++) begin
      num = $urandom_range(0, 4);
      for (int i = 0; i < NW; i++) begin
        disp_T[i]    = ($urandom_range(0, 59) == 0) ? 7'd0 : new_tag();
        disp_Told[i] = 7'($urandom_range(0, 127));
        disp_dest[i] = 5'($urandom_range(0, 31));
      end
      for (int l = 0; l < NW; l++) begin
        sel          = $urandom_range(0, 9);
        cdb_valid[l] = 1'b1;
        if (sel < 5 && mq.size() > 0) cdb_tag[l] = mq[$urandom_range(0, mq.size() - 1)].t;
        else if (sel < 7) cdb_tag[l] = 7'($urandom_range(0, 127));
        else if (sel == 7) cdb_tag[l] = disp_T[l];
        else begin
          cdb_valid[l] = 1'b0;
          cdb_tag[l]   = 7'($urandom_range(1, 127));
        end
      end
      step(num, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0, 1'b1);
    end

    // drain: complete pending entries, then flush anything stuck on tag 0
    set_disp(0);
    for (int c = 0; c < 60; c++) begin
      for (int l = 0; l < NW; l++) begin
        cdb_valid[l] = mq.size() > 0;
        cdb_tag[l]   = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].t : 7'd0;
      end
      step(0, 1'b0, 1'b0, 1'b1);
    end
    set_cdb(0, 0, 0);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    check("scoreboard_drain", cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL use the parameter `N_WAY, default 3: dispatch, complete and retire width.
REQ-002 SHALL use the parameter `N_ROB, default 32: entry count.
REQ-003 SHALL use the parameter `CDB_BITS, default 7: physical tag width; tag 0 = none/invalid.
REQ-004 SHALL use the parameter `SD: register update delay on all flop assignments.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 flush  in  1  squash all entries.
REQ-008 disp_num  in  $clog2(`N_WAY)+1  instructions offered this cycle, in slots 0..disp_num-1.
REQ-009 disp_T  in  `N_WAY x `CDB_BITS  new destination tag per slot.
REQ-010 disp_Told  in  `N_WAY x `CDB_BITS  previous mapping of the destination per slot.
REQ-011 disp_dest  in  `N_WAY x 5  architectural destination per slot.
REQ-012 cdb_valid  in  `N_WAY  completion broadcast valid per lane.
REQ-013 cdb_tag  in  `N_WAY x `CDB_BITS  completing tag per lane.
REQ-014 dispatched  out  `N_WAY  per-slot accept; feeds the free-list return handshake.
REQ-015 rob_told  out  `N_WAY x `CDB_BITS  Told of each retiring slot, 0 otherwise; feeds the free list.
REQ-016 retire_valid  out  `N_WAY  slot retires this cycle.
REQ-017 retire_T  out  `N_WAY x `CDB_BITS  T of each retiring slot, 0 otherwise.
REQ-018 retire_dest  out  `N_WAY x 5  arch destination of each retiring slot, 0 otherwise.
REQ-019 rob_free_num  out  $clog2(`N_WAY)+1  min(`N_ROB - count, `N_WAY), taken from registered count.

Function
REQ-020 SHALL hold per entry: valid, complete, T, Told, dest; head, tail and count registers; head/tail wrap modulo `N_ROB.
REQ-021 SHALL set dispatched[i]=1 iff i < disp_num, i < rob_free_num and !flush; slots are contiguous from slot 0.
REQ-022 SHALL write each accepted slot i to entry (tail+i) mod `N_ROB with valid=1; tail advances by the accepted count at the next edge.
REQ-023 SHALL set complete on a valid entry at the next edge when any cdb_valid lane carries cdb_tag == entry T and T != 0.
REQ-024 SHALL mark an entry dispatched in the same cycle as its matching CDB broadcast as complete on write (bypass).
REQ-025 SHALL retire entries combinationally from registered state: slot k retires iff entries head..head+k are all valid and complete, k < `N_WAY, and !flush.
REQ-026 SHALL drive rob_told, retire_T and retire_dest for retiring slots, packed from slot 0, and zeros in non-retiring slots.
REQ-027 SHALL pass Told=0 through unchanged on retire with retire_valid=1; the free list ignores tag 0.
REQ-028 SHALL clear valid and complete on retired entries, advance head by the retired count, and update count = count + accepted - retired, all at the same edge.
REQ-029 SHALL compute same-cycle retire and dispatch independently; space freed by a retire is usable from the next cycle only.
REQ-030 SHALL, when full (count == `N_ROB), drive rob_free_num=0 and dispatched=0.
REQ-031 SHALL never retire past the tail; when empty, retire_valid=0.
REQ-032 SHALL, on flush, drive retire_valid=0, rob_told=0 and dispatched=0 that cycle, and at the next edge clear all valid bits and set head=tail=count=0.
REQ-033 SHALL be neutral to CDB tags matching no valid entry.

Reset
REQ-034 SHALL, on reset, set head=tail=count=0 and clear all valid and complete bits; reset dominates flush and dispatch.
REQ-035 SHALL, in the cycle after reset, drive rob_told=0, retire_valid=0 and rob_free_num=`N_WAY; dispatched follows REQ-021.

Verification (`N_WAY=3, `N_ROB=32)
REQ-036 SHALL cover basic dispatch: after reset, disp_num=3, T={33,34,35}, Told={1,2,3} -> dispatched=111; next cycle count=3, rob_free_num=3, retire_valid=000.
REQ-037 SHALL cover out-of-order completion: CDB 35 then 34 -> no retire; CDB 33 -> next cycle retire_valid=111, rob_told={1,2,3}, retire_T={33,34,35}.
REQ-038 SHALL cover the full condition: fill to 32 entries -> rob_free_num=0, dispatched=000; with one head retire and disp_num=3 in the same cycle -> dispatched=000, next cycle rob_free_num=1.
REQ-039 SHALL cover wrap-around: head=31 with entries 31,0,1 complete -> one-cycle retire of all three, head=2.
REQ-040 SHALL cover bypass: dispatch T=40 at head of an empty ROB with cdb_tag=40 in the same cycle -> retire_valid=001, rob_told=Told next cycle.
REQ-041 SHALL cover flush and reset mid-operation: assert flush or reset with 10 entries, some complete -> no retire that cycle; next cycle count=0, rob_free_num=3.
